dma_channel_arbiter: RTL
========================

Name: dma_channel_arbiter

Overview:
Resolves DMA channel priority and runs the hold-request/hold-acknowledge handshake for the 4-channel DMA controller. It samples DREQ against the mask register, raises HRQ to the CPU, latches a winning channel when HLDA arrives, drives the one-hot DACK, and kicks the timing-and-control FSM. It releases the bus after each completed transfer (single-transfer mode) and tracks per-channel terminal-count status.

Parameters:
NUM_CH, 4, number of DMA channels; supported value is 4.
CH_W, $clog2(NUM_CH), width of the channel index; derived, not overridden.

Ports:
CLK  input  1  system clock; all logic on rising edge
RESET  input  1  synchronous, active-high reset
DREQ  input  NUM_CH  channel DMA requests, active-high, level
MASK  input  NUM_CH  mask register; 1 = channel ignored
HLDA  input  1  hold acknowledge from CPU
cycleDone  input  1  1-cycle pulse from timing-and-control at end of a transfer (S4)
terminalCount  input  1  qualifies cycleDone: the active channel reached TC
statusClear  input  1  1-cycle pulse; clears tcStatus
HRQ  output  1  hold request to CPU
DACK  output  NUM_CH  one-hot acknowledge for the active channel
activeChannel  output  CH_W  index of the granted channel; valid while grantValid
grantValid  output  1  high while DACK is driven
startCycle  output  1  1-cycle pulse starting a transfer in timing-and-control
abortPulse  output  1  1-cycle pulse when HLDA drops during a grant
tcStatus  output  NUM_CH  sticky per-channel TC flags

Behaviour:
- Reset values: HRQ=0, DACK=0, activeChannel=0, grantValid=0, startCycle=0, abortPulse=0, tcStatus=0, state=IDLE, priority pointer = channel 0 highest.
- RESET is sampled every edge. It takes effect mid-grant with no abortPulse and no tcStatus update.
- pending = DREQ & ~MASK.
- One-hot FSM:
  - IDLE: HRQ=0, DACK=0. If pending != 0, go to HOLDREQ (HRQ high from the next cycle).
  - HOLDREQ: HRQ=1.
    - pending==0 (request withdrawn): go to IDLE. HRQ drops the next cycle, even if HLDA=1 that cycle.
    - HLDA=1 and pending!=0: latch the priority winner of pending in this same cycle and go to GRANTED. The next cycle has DACK[winner]=1, grantValid=1, startCycle=1 (one cycle only).
  - GRANTED: HRQ=1. DACK and activeChannel are held constant. DREQ and MASK changes are ignored.
    - cycleDone=1: go to RELEASE.
      - If terminalCount=1, set tcStatus[activeChannel].
      - Update the priority pointer (see Optional Feature).
    - HLDA=0 (without cycleDone): go to IDLE, pulse abortPulse, no rotation, no tcStatus change.
    - cycleDone and HLDA=0 in the same cycle: cycleDone wins.
  - RELEASE: HRQ=0, DACK=0, grantValid=0. Stay until HLDA=0, then go to IDLE. Pending requests are not re-arbitrated before IDLE, so there is a minimum 1-cycle HRQ gap.
- Latency: DREQ rise in IDLE gives HRQ at +1 cycle. HLDA sampled high gives DACK/startCycle at +1 cycle.
- tcStatus: a set and statusClear in the same cycle resolves with the set winning for that bit; other bits clear.
- All outputs are registered.

Optional Feature:
Macro DMA_ROTATING_PRIORITY_EN.
- Defined: rotating priority. After a completed service (cycleDone) of channel n, channel n becomes lowest and (n+1) mod NUM_CH becomes highest. An aborted grant does not rotate.
- Undefined: fixed priority, ch0 > ch1 > ch2 > ch3. The pointer register is absent and the winner is the lowest-indexed pending bit.

Decomposition:
- Package dma_arb_pkg holds:
  - NUM_CH default constant.
  - One-hot state typedef: IDLE=4'b0001, HOLDREQ=4'b0010, GRANTED=4'b0100, RELEASE=4'b1000.
  - Channel index typedef.
- One combinational sub-module, dma_prio_encoder: inputs are pending and highest-priority pointer; outputs are winner index and a valid flag. It is instantiated once and handles both fixed mode (pointer tied to 0) and rotating mode.

Test Plan:
- DREQ=4'b0100, MASK=0, HLDA raised 3 cycles after HRQ -> HRQ at +1; DACK=4'b0100, activeChannel=2, startCycle 1 cycle after HLDA; cycleDone -> DACK=0, HRQ=0; IDLE once HLDA=0.
- DREQ=4'b1010, MASK=4'b0010 -> channel 3 granted, DACK=4'b1000.
- DREQ asserted then dropped before HLDA -> HRQ deasserts next cycle, no DACK, no startCycle.
- DMA_ROTATING_PRIORITY_EN: DREQ=4'b1111 held, 4 full services -> grant order 0,1,2,3. Without the macro -> 0,0,0,0.
- HLDA dropped mid-GRANTED on channel 1 -> abortPulse=1 one cycle, DACK=0, tcStatus unchanged, next grant still starts at channel 1 (rotating).
- cycleDone with terminalCount on channel 2, then statusClear -> tcStatus=4'b0100, then 0. RESET mid-GRANTED -> all outputs 0 next cycle.

Source files
------------

// File: rtl/dma_arb_pkg.sv
// Shared types and constants for the DMA channel arbiter.
package dma_arb_pkg;

    localparam int NUM_CH_DEF = 4;
    localparam int CH_W_DEF   = $clog2(NUM_CH_DEF);

    // One-hot handshake states
    typedef enum logic [3:0] {
        IDLE    = 4'b0001,
        HOLDREQ = 4'b0010,
        GRANTED = 4'b0100,
        RELEASE = 4'b1000
    } arb_state_e;

    typedef logic [CH_W_DEF-1:0] ch_idx_t;

endpackage

// File: rtl/dma_prio_encoder.sv
// Priority encoder: scans pending starting at hi_ptr and wrapping around,
// so hi_ptr tied to zero gives plain lowest-index-wins priority.
module dma_prio_encoder
    import dma_arb_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    localparam int CH_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] pending,
    input  logic [CH_W-1:0]   hi_ptr,
    output logic [CH_W-1:0]   winner,
    output logic              valid
);

    logic [CH_W-1:0] idx;

    // First pending channel found walking upward from hi_ptr wins
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = CH_W'((int'(hi_ptr) + i) % NUM_CH);
            if (!valid && pending[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_channel_arbiter.sv
// DMA channel arbiter: HRQ/HLDA handshake, channel grant, TC status.
// Optional macro DMA_ROTATING_PRIORITY_EN selects rotating priority
// (served channel drops to lowest); default is fixed ch0 > ch1 > ch2 > ch3.
module dma_channel_arbiter
    import dma_arb_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    localparam int CH_W  = $clog2(NUM_CH)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NUM_CH-1:0] DREQ,
    input  logic [NUM_CH-1:0] MASK,
    input  logic              HLDA,
    input  logic              cycleDone,
    input  logic              terminalCount,
    input  logic              statusClear,
    output logic              HRQ,
    output logic [NUM_CH-1:0] DACK,
    output logic [CH_W-1:0]   activeChannel,
    output logic              grantValid,
    output logic              startCycle,
    output logic              abortPulse,
    output logic [NUM_CH-1:0] tcStatus
);

    arb_state_e        state, state_n;
    logic [NUM_CH-1:0] pending;
    logic [CH_W-1:0]   hi_ptr, win, act_n;
    logic              win_vld;
    logic              hrq_n, gv_n, start_n, abort_n;
    logic [NUM_CH-1:0] dack_n, tc_n;

    assign pending = DREQ & ~MASK;

`ifdef DMA_ROTATING_PRIORITY_EN
    logic [CH_W-1:0] ptr_q, ptr_n;
    assign hi_ptr = ptr_q;
`else
    assign hi_ptr = '0;
`endif

    dma_prio_encoder #(.NUM_CH(NUM_CH)) u_prio (
        .pending (pending),
        .hi_ptr  (hi_ptr),
        .winner  (win),
        .valid   (win_vld)
    );

    // Next state plus next values of every registered output
    always_comb begin
        state_n = state;
        act_n   = activeChannel;
        start_n = 1'b0;
        abort_n = 1'b0;
        tc_n    = statusClear ? '0 : tcStatus;
`ifdef DMA_ROTATING_PRIORITY_EN
        ptr_n   = ptr_q;
`endif
        case (state)
            IDLE: begin
                if (|pending) state_n = HOLDREQ;
            end
            HOLDREQ: begin
                if (!(|pending)) begin
                    state_n = IDLE;
                end else if (HLDA && win_vld) begin
                    state_n = GRANTED;
                    act_n   = win;
                    start_n = 1'b1;
                end
            end
            GRANTED: begin
                // cycleDone takes precedence over a simultaneous HLDA drop
                if (cycleDone) begin
                    state_n = RELEASE;
                    if (terminalCount) tc_n[activeChannel] = 1'b1;
`ifdef DMA_ROTATING_PRIORITY_EN
                    ptr_n = (activeChannel == CH_W'(NUM_CH - 1)) ? '0
                                                                 : activeChannel + 1'b1;
`endif
                end else if (!HLDA) begin
                    state_n = IDLE;
                    abort_n = 1'b1;
                end
            end
            RELEASE: begin
                if (!HLDA) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        hrq_n  = (state_n == HOLDREQ) || (state_n == GRANTED);
        gv_n   = (state_n == GRANTED);
        dack_n = gv_n ? (NUM_CH'(1) << act_n) : '0;
    end

    // State and output registers; reset overrides everything mid-grant
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state         <= IDLE;
            HRQ           <= 1'b0;
            DACK          <= '0;
            activeChannel <= '0;
            grantValid    <= 1'b0;
            startCycle    <= 1'b0;
            abortPulse    <= 1'b0;
            tcStatus      <= '0;
`ifdef DMA_ROTATING_PRIORITY_EN
            ptr_q         <= '0;
`endif
        end else begin
            state         <= state_n;
            HRQ           <= hrq_n;
            DACK          <= dack_n;
            activeChannel <= act_n;
            grantValid    <= gv_n;
            startCycle    <= start_n;
            abortPulse    <= abort_n;
            tcStatus      <= tc_n;
`ifdef DMA_ROTATING_PRIORITY_EN
            ptr_q         <= ptr_n;
`endif
        end
    end

endmodule
